// File: rtl/cutoff_envelope.sv
// Attack/decay/sustain/release envelope that produces the alpha coefficient of a
// one-pole lowpass. All state advances only on sample_tick strobes.
module cutoff_envelope #(
  parameter int ALPHA_MIN = 16,
  parameter int ALPHA_MAX = 200,
  parameter int RATE_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic                 gate,
  input  logic [RATE_BITS-1:0] attack_rate,
  input  logic [RATE_BITS-1:0] decay_rate,
  input  logic [RATE_BITS-1:0] release_rate,
  input  logic [7:0]           sustain,
  output logic signed [8:0]    alpha,
  output logic [2:0]           state,
  output logic                 done
);

  localparam logic [7:0] AMIN = 8'(ALPHA_MIN);
  localparam logic [7:0] AMAX = 8'(ALPHA_MAX);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           level_q, level_d;
  logic [RATE_BITS-1:0] presc_q, presc_d;
  logic                 gate_prev_q;
  logic                 armed_q;
  logic                 done_q, done_d;

  logic [RATE_BITS-1:0] active_rate;
  logic [RATE_BITS-1:0] presc_inc;
  logic [7:0]           sus_eff;
  logic [7:0]           lvl_up, lvl_dn;
  logic                 step, rise;

  function automatic logic [7:0] sat_inc(input logic [7:0] l);
    return (l >= AMAX) ? AMAX : l + 8'd1;
  endfunction

  function automatic logic [7:0] sat_dec(input logic [7:0] l);
    return (l <= AMIN) ? AMIN : l - 8'd1;
  endfunction

  function automatic logic [7:0] clamp_level(input logic [7:0] l);
    if (l < AMIN) return AMIN;
    if (l > AMAX) return AMAX;
    return l;
  endfunction

  // A rise only counts once gate has been seen low since reset, so a gate
  // still held high across a reset cannot restart the envelope.
  assign rise    = gate & ~gate_prev_q & armed_q;
  assign sus_eff = clamp_level(sustain);
  assign lvl_up  = sat_inc(level_q);
  assign lvl_dn  = sat_dec(level_q);

  always_comb begin
    case (state_q)
      ATTACK:  active_rate = attack_rate;
      DECAY:   active_rate = decay_rate;
      RELEASE: active_rate = release_rate;
      default: active_rate = '0;
    endcase
  end

  assign step      = (presc_q == active_rate);
  assign presc_inc = step ? '0 : presc_q + RATE_BITS'(1);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        level_d = AMIN;
        presc_d = '0;
        if (rise) state_d = ATTACK;
      end
      ATTACK: begin
        presc_d = presc_inc;
        if (step) level_d = lvl_up;
        if (!gate) state_d = RELEASE;
        else if (step && lvl_up == AMAX) state_d = DECAY;
      end
      DECAY: begin
        presc_d = presc_inc;
        if (!gate) begin
          if (step) level_d = lvl_dn;
          state_d = RELEASE;
        end else if (level_q <= sus_eff) begin
          level_d = sus_eff;
          state_d = SUSTAIN;
        end else if (step) begin
          if (lvl_dn <= sus_eff) begin
            level_d = sus_eff;
            state_d = SUSTAIN;
          end else begin
            level_d = lvl_dn;
          end
        end
      end
      SUSTAIN: begin
        presc_d = '0;
        level_d = sus_eff;
        if (!gate) state_d = RELEASE;
      end
      RELEASE: begin
        presc_d = presc_inc;
        if (rise) begin
          state_d = ATTACK;
        end else if (step) begin
          level_d = lvl_dn;
          if (lvl_dn <= AMIN) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        level_d = AMIN;
        presc_d = '0;
      end
    endcase
    if (state_d != state_q) presc_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      level_q     <= AMIN;
      presc_q     <= '0;
      gate_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= sample_tick & done_d;
      if (sample_tick) begin
        state_q     <= state_d;
        level_q     <= level_d;
        presc_q     <= presc_d;
        gate_prev_q <= gate;
        if (!gate) armed_q <= 1'b1;
      end
    end
  end

  assign alpha = {1'b0, level_q};
  assign state = state_q;
  assign done  = done_q;

endmodule
